shift_register_piso: RTL

Parallel-in, serial-out transmitter: accepts a WIDTH-bit word over a valid/ready handshake and shifts it out LSB-first on a single line, advancing one bit per cycle in which `en` is high. It is the transmit end paired with the codebase's enabled SIPO shift register (`shift_register_en`). With the same `en` cadence, that register reconstructs the word after WIDTH enabled edges. Back-to-back words are supported with no idle gap.

---
 rtl/shift_register_piso_if.sv | 11 +
 rtl/shift_register_piso.sv | 74 +++++++
 2 files changed

// File: rtl/shift_register_piso_if.sv
// Word handshake between a sender and the PISO transmitter.
interface shift_register_piso_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;

    modport master (output din, output din_valid, input din_ready);
    modport slave  (input din, input din_valid, output din_ready);
endinterface

// File: rtl/shift_register_piso.sv
// Parallel-in serial-out transmitter, LSB first, one bit per enabled edge.
//   state | meaning
//   IDLE  | line at 0, waiting for a word
//   SHIFT | sr[0] on the line, cnt = bits still to retire after the current one
module shift_register_piso #(
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    shift_register_piso_if.slave  bus,
    output logic                  serial_out,
    output logic                  busy,
    output logic                  done
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] sr, sr_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             last;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            sr    <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            sr    <= sr_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        sr_nxt    = sr;
        cnt_nxt   = cnt;
        last      = (state == SHIFT) && (cnt == '0) && en;
        unique case (state)
            IDLE: begin
                if (bus.din_valid) begin
                    sr_nxt    = bus.din;
                    cnt_nxt   = CNT_TOP;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (en) begin
                    if (cnt != '0) begin
                        sr_nxt  = {1'b0, sr[WIDTH-1:1]};
                        cnt_nxt = cnt - 1'b1;
                    end else if (bus.din_valid) begin
                        // Reload on the retiring edge so the next word follows with no gap.
                        sr_nxt  = bus.din;
                        cnt_nxt = CNT_TOP;
                    end else begin
                        sr_nxt    = '0;
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign serial_out    = sr[0];
    assign busy          = (state == SHIFT);
    assign done          = last;
    assign bus.din_ready = (state == IDLE) || last;
endmodule
